// File: rtl/temp_spi_reader.sv
// Periodic reader for a TMP121-class SPI temperature sensor; publishes whole degrees C
// (saturated to 0..63), the raw 13-bit code and a bus-stuck-high fault flag.
module temp_spi_reader #(
  parameter int CLK_DIV       = 25,
  parameter int SAMPLE_CYCLES = 25_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        miso,
  output logic        cs_n,
  output logic        sclk,
  output logic [7:0]  temptDone,
  output logic        load,
  output logic [12:0] raw,
  output logic        fault
);

  localparam int CNT_W = $clog2(SAMPLE_CYCLES);
  localparam int DIV_W = $clog2(CLK_DIV);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, CONVERT, STROBE} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DIV_W-1:0]   div_q;
  logic [5:0]         hp_q;
  logic [5:0]         hp_d;
  logic [15:0]        sr_q;
  logic               cs_n_q;
  logic               sclk_q;
  logic               load_q;
  logic               fault_q;
  logic [7:0]         temp_q;
  logic [12:0]        raw_q;
  logic               half_tick;
  logic               sample_en;

  // Negative readings clamp to 0; anything above 63 C clamps to 63.
  function automatic logic [7:0] to_degc(input logic signed [12:0] code);
    logic signed [12:0] whole;
    whole = code >>> 4;
    if (code < 0)
      return 8'd0;
    else if (whole > 13'sd63)
      return 8'd63;
    else
      return {2'b00, whole[5:0]};
  endfunction

  assign half_tick = (div_q == DIV_W'(CLK_DIV - 1));
  assign hp_d      = hp_q + 6'd1;
  // Odd half-period events are SCLK rising edges, where MISO is captured.
  assign sample_en = ((state_q == SETUP) || (state_q == SHIFT)) && half_tick && hp_d[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (cnt_q == '0)
      cnt_q <= CNT_W'(SAMPLE_CYCLES - 1);
    else
      cnt_q <= cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (sample_en)
      sr_q <= {sr_q[14:0], miso};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      hp_q    <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      load_q  <= 1'b0;
      fault_q <= 1'b0;
      temp_q  <= '0;
      raw_q   <= '0;
    end else begin
      load_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if ((cnt_q == '0) && enable) begin
            state_q <= SETUP;
            cs_n_q  <= 1'b0;
            div_q   <= '0;
            hp_q    <= '0;
          end
        end
        SETUP, SHIFT: begin
          if (half_tick) begin
            div_q   <= '0;
            hp_q    <= hp_d;
            sclk_q  <= hp_d[0];
            state_q <= (hp_d == 6'd32) ? HOLD : SHIFT;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        HOLD: begin
          if (half_tick) begin
            cs_n_q  <= 1'b1;
            state_q <= CONVERT;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        CONVERT: begin
          if (sr_q == 16'hFFFF) begin
            fault_q <= 1'b1;
          end else begin
            fault_q <= 1'b0;
            raw_q   <= sr_q[15:3];
            temp_q  <= to_degc(sr_q[15:3]);
          end
          state_q <= STROBE;
        end
        STROBE: begin
          load_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cs_n      = cs_n_q;
  assign sclk      = sclk_q;
  assign load      = load_q;
  assign fault     = fault_q;
  assign temptDone = temp_q;
  assign raw       = raw_q;

endmodule

// File: tb/tb_temp_spi_reader.sv
// Directed bench for temp_spi_reader with a behavioural sensor and an expected-result queue.
module tb_temp_spi_reader;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        miso;
  logic        cs_n;
  logic        sclk;
  logic [7:0]  temptDone;
  logic        load;
  logic [12:0] raw;
  logic        fault;

  typedef struct {
    logic [7:0]  t;
    logic [12:0] r;
    logic        f;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [15:0] sensor_frame;
  logic [15:0] cur_frame;
  int          idx;
  logic        in_frame;
  logic [7:0]  m_temp;
  logic [12:0] m_raw;
  logic        m_fault;

  temp_spi_reader #(.CLK_DIV(4), .SAMPLE_CYCLES(200)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .miso(miso),
    .cs_n(cs_n), .sclk(sclk), .temptDone(temptDone), .load(load),
    .raw(raw), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Sensor: first bit presented at CS fall, next bit after every SCLK fall.
  initial begin
    in_frame = 1'b0;
    idx      = 0;
    miso     = 1'b0;
    cur_frame = 16'h0;
  end
  always @(negedge cs_n or posedge cs_n or negedge sclk) begin
    if (cs_n) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      in_frame  = 1'b1;
      cur_frame = sensor_frame;
      idx       = 15;
    end else if (!sclk) begin
      idx = idx - 1;
    end
    miso = (in_frame && idx >= 0) ? cur_frame[idx] : 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_temp  = 8'd0;
    m_raw   = 13'd0;
    m_fault = 1'b0;
  endtask

  // Independent reference: integer division of the non-negative code.
  task automatic push_frame(input logic [15:0] f);
    logic signed [12:0] cs;
    int c;
    int d;
    exp_t e;
    sensor_frame = f;
    if (f == 16'hFFFF) begin
      m_fault = 1'b1;
    end else begin
      m_fault = 1'b0;
      cs      = f[15:3];
      c       = cs;
      m_raw   = f[15:3];
      if (c < 0) begin
        m_temp = 8'd0;
      end else begin
        d      = c / 16;
        m_temp = (d > 63) ? 8'd63 : d[7:0];
      end
    end
    e.t = m_temp;
    e.r = m_raw;
    e.f = m_fault;
    exp_q.push_back(e);
  endtask

  task automatic wait_cs_low(output int t0);
    int w;
    w = 0;
    while (cs_n !== 1'b0 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    chk("cs_fall_seen", (w < 2000), 1);
    t0 = cyc;
  endtask

  task automatic watch(input int dis_at, output int t0, output int low, output int rises,
                       output int fr, output int lr, output int ld_cyc, output int ld_cnt,
                       output logic [7:0] t133);
    logic ps;
    exp_t e;
    wait_cs_low(t0);
    low = 0; rises = 0; fr = -1; lr = -1; ld_cyc = -1; ld_cnt = 0; t133 = 8'hxx;
    ps = sclk;
    for (int n = 0; n <= 140; n++) begin
      if (n > 0) @(negedge clk);
      if (n == dis_at) enable = 1'b0;
      if (cs_n === 1'b0) low++;
      if (sclk === 1'b1 && ps === 1'b0) begin
        rises++;
        if (fr < 0) fr = cyc;
        lr = cyc;
      end
      ps = sclk;
      if (n == 133) t133 = temptDone;
      if (load === 1'b1) begin
        ld_cnt++;
        ld_cyc = cyc;
        chk("sb_pending", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("sb_temptDone", temptDone, e.t);
          chk("sb_raw", raw, e.r);
          chk("sb_fault", fault, e.f);
        end
      end
    end
  endtask

  initial begin
    int t0, t0b, low, rises, fr, lr, ld_cyc, ld_cnt, rel, nlow;
    logic [7:0] t133;

    rst_n = 1'b0;
    enable = 1'b1;
    sensor_frame = 16'h0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_load", load, 0);
    chk("rst_temptDone", temptDone, 0);
    chk("rst_raw", raw, 0);
    chk("rst_fault", fault, 0);

    // Test 1: basic frame timing
    push_frame(16'h0C80);
    rel = cyc;
    rst_n = 1'b1;
    watch(-1, t0, low, rises, fr, lr, ld_cyc, ld_cnt, t133);
    chk("t1_first_start", t0, rel + 1);
    chk("t1_cs_low_clks", low, 132);
    chk("t1_sclk_pulses", rises, 16);
    chk("t1_first_rise", fr, t0 + 4);
    chk("t1_rise_span", lr - fr, 120);
    chk("t1_temp_before_load", t133, 25);
    chk("t1_load_cycle", ld_cyc, t0 + 134);
    chk("t1_load_width", ld_cnt, 1);

    // Test 2: fractional, saturating and negative readings
    push_frame(16'h0CF8);
    watch(-1, t0b, low, rises, fr, lr, ld_cyc, ld_cnt, t133);
    chk("t1_next_frame", t0b - t0, 200);
    push_frame(16'h3200);
    watch(-1, t0, low, rises, fr, lr, ld_cyc, ld_cnt, t133);
    chk("t2_sat_load", ld_cnt, 1);
    push_frame(16'hFD80);
    watch(-1, t0, low, rises, fr, lr, ld_cyc, ld_cnt, t133);
    chk("t2_neg_load", ld_cnt, 1);

    // Test 3: stuck-high frame between good frames
    push_frame(16'h0C80);
    watch(-1, t0, low, rises, fr, lr, ld_cyc, ld_cnt, t133);
    push_frame(16'hFFFF);
    watch(-1, t0, low, rises, fr, lr, ld_cyc, ld_cnt, t133);
    chk("t3_fault_load", ld_cnt, 1);
    chk("t3_fault_hold_temp", temptDone, 25);
    push_frame(16'h0C80);
    watch(-1, t0, low, rises, fr, lr, ld_cyc, ld_cnt, t133);
    chk("t3_fault_cleared", fault, 0);

    // Test 4: enable dropped mid-frame, then restored
    push_frame(16'h0640);
    watch(50, t0, low, rises, fr, lr, ld_cyc, ld_cnt, t133);
    chk("t4_frame_completes", ld_cnt, 1);
    chk("t4_cs_low_clks", low, 132);
    nlow = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (cs_n === 1'b0) nlow++;
    end
    chk("t4_no_frames", nlow, 0);
    push_frame(16'h0C80);
    enable = 1'b1;
    watch(-1, t0b, low, rises, fr, lr, ld_cyc, ld_cnt, t133);
    chk("t4_resume_phase", t0b - t0, 800);

    // Test 5: reset in the middle of a frame
    sensor_frame = 16'h3200;
    wait_cs_low(t0);
    repeat (70) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_cs_n", cs_n, 1);
    chk("t5_sclk", sclk, 0);
    chk("t5_temptDone", temptDone, 0);
    chk("t5_load", load, 0);
    chk("t5_raw", raw, 0);
    model_reset();
    exp_q.delete();
    ld_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (load === 1'b1) ld_cnt++;
    end
    chk("t5_no_load", ld_cnt, 0);
    push_frame(16'h0C80);
    rel = cyc;
    rst_n = 1'b1;
    watch(-1, t0, low, rises, fr, lr, ld_cyc, ld_cnt, t133);
    chk("t5_restart", t0, rel + 1);
    chk("t5_load_cycle", ld_cyc, t0 + 134);

    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
